// File: rtl/screen_fill_if.sv
// Pixel-fill request/response bundle between a controller and screen_fill.
// The master side requests fills; the slave side streams plotted pixels back.
interface screen_fill_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);
  logic                start;
  logic                mode;
  logic [X_W-1:0]      rect_x0;
  logic [Y_W-1:0]      rect_y0;
  logic [X_W-1:0]      rect_w;
  logic [Y_W-1:0]      rect_h;
  logic [COLOUR_W-1:0] fill_colour;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;
  logic                done;

  modport master (
    output start, mode, rect_x0, rect_y0, rect_w, rect_h, fill_colour,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, mode, rect_x0, rect_y0, rect_w, rect_h, fill_colour,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/screen_fill.sv
// Raster-order screen/rectangle filler: clips the requested region to the
// visible screen and emits one plot strobe per pixel, then pulses done.
module screen_fill #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic          clock,
  input  logic          reset,
  screen_fill_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Clip arithmetic is one bit wider than the coordinates so it cannot wrap.
  localparam logic [X_W:0]   SCREEN_W_E = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   SCREEN_H_E = (Y_W+1)'(SCREEN_H);
  localparam logic [X_W:0]   X_ZERO_E   = {(X_W+1){1'b0}};
  localparam logic [Y_W:0]   Y_ZERO_E   = {(Y_W+1){1'b0}};
  localparam logic [X_W-1:0] X_ONE      = {{(X_W-1){1'b0}}, 1'b1};
  localparam logic [Y_W-1:0] Y_ONE      = {{(Y_W-1){1'b0}}, 1'b1};

  state_t              state_r, state_s;
  logic [X_W-1:0]      x_r, x_s, x0_r, x0_s, x_last_r, x_last_s;
  logic [Y_W-1:0]      y_r, y_s, y_last_r, y_last_s;
  logic [COLOUR_W-1:0] colour_r, colour_s;
  logic                plot_r, plot_s, busy_r, busy_s, done_r, done_s;

  logic [X_W:0]        rx0_e_s, rw_e_s, x_room_s, cw_s;
  logic [Y_W:0]        ry0_e_s, rh_e_s, y_room_s, ch_s;
  logic [X_W-1:0]      cx0_s, cx_last_s;
  logic [Y_W-1:0]      cy0_s, cy_last_s;
  logic                empty_s;

  assign rx0_e_s  = {1'b0, bus.rect_x0};
  assign rw_e_s   = {1'b0, bus.rect_w};
  assign ry0_e_s  = {1'b0, bus.rect_y0};
  assign rh_e_s   = {1'b0, bus.rect_h};
  assign x_room_s = SCREEN_W_E - rx0_e_s;
  assign y_room_s = SCREEN_H_E - ry0_e_s;

  // Region selection and clipping of the requested rectangle to the screen.
  always_comb begin
    cx0_s = {X_W{1'b0}};
    cy0_s = {Y_W{1'b0}};
    cw_s  = SCREEN_W_E;
    ch_s  = SCREEN_H_E;
    if (bus.mode == 1'b1) begin
      cx0_s = bus.rect_x0;
      cy0_s = bus.rect_y0;
      if (rx0_e_s >= SCREEN_W_E) begin
        cw_s = X_ZERO_E;
      end else if (rw_e_s < x_room_s) begin
        cw_s = rw_e_s;
      end else begin
        cw_s = x_room_s;
      end
      if (ry0_e_s >= SCREEN_H_E) begin
        ch_s = Y_ZERO_E;
      end else if (rh_e_s < y_room_s) begin
        ch_s = rh_e_s;
      end else begin
        ch_s = y_room_s;
      end
    end else begin
      cw_s = SCREEN_W_E;
      ch_s = SCREEN_H_E;
    end
  end

  assign empty_s   = (cw_s == X_ZERO_E) || (ch_s == Y_ZERO_E);
  assign cx_last_s = cx0_s + cw_s[X_W-1:0] - X_ONE;
  assign cy_last_s = cy0_s + ch_s[Y_W-1:0] - Y_ONE;

  // Next-state and next-output logic for the fill sequencer.
  always_comb begin
    state_s  = state_r;
    x_s      = x_r;
    y_s      = y_r;
    colour_s = colour_r;
    x0_s     = x0_r;
    x_last_s = x_last_r;
    y_last_s = y_last_r;
    plot_s   = 1'b0;
    busy_s   = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.start == 1'b1) begin
          colour_s = bus.fill_colour;
          x0_s     = cx0_s;
          x_last_s = cx_last_s;
          y_last_s = cy_last_s;
          if (empty_s) begin
            state_s = S_DONE;
            done_s  = 1'b1;
          end else begin
            state_s = S_FILL;
            x_s     = cx0_s;
            y_s     = cy0_s;
            plot_s  = 1'b1;
            busy_s  = 1'b1;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FILL: begin
        plot_s = 1'b1;
        busy_s = 1'b1;
        if (x_r == x_last_r) begin
          if (y_r == y_last_r) begin
            state_s = S_DONE;
            plot_s  = 1'b0;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            x_s = x0_r;
            y_s = y_r + Y_ONE;
          end
        end else begin
          x_s = x_r + X_ONE;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= S_IDLE;
      x_r      <= {X_W{1'b0}};
      y_r      <= {Y_W{1'b0}};
      colour_r <= {COLOUR_W{1'b0}};
      x0_r     <= {X_W{1'b0}};
      x_last_r <= {X_W{1'b0}};
      y_last_r <= {Y_W{1'b0}};
      plot_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      x_r      <= x_s;
      y_r      <= y_s;
      colour_r <= colour_s;
      x0_r     <= x0_s;
      x_last_r <= x_last_s;
      y_last_r <= y_last_s;
      plot_r   <= plot_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign bus.x      = x_r;
  assign bus.y      = y_r;
  assign bus.colour = colour_r;
  assign bus.plot   = plot_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;

endmodule

// File: tb/tb_screen_fill.sv
// Directed self-checking bench for screen_fill: reset, full/rectangle fills,
// clipping, degenerate regions, ignored starts and reset during a fill.
module tb_screen_fill;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int COLOUR_W = 3;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  screen_fill_if #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W)) bus ();

  screen_fill #(
    .SCREEN_W(160), .SCREEN_H(120), .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a request at the current falling edge, then scramble the inputs.
  task automatic do_start(input logic m, input int x0, input int y0, input int w,
                          input int h, input int col);
    bus.mode        = m;
    bus.rect_x0     = X_W'(x0);
    bus.rect_y0     = Y_W'(y0);
    bus.rect_w      = X_W'(w);
    bus.rect_h      = Y_W'(h);
    bus.fill_colour = COLOUR_W'(col);
    bus.start       = 1'b1;
    @(negedge clock);
    bus.start       = 1'b0;
    bus.mode        = ~m;
    bus.rect_x0     = ~bus.rect_x0;
    bus.rect_y0     = ~bus.rect_y0;
    bus.rect_w      = ~bus.rect_w;
    bus.rect_h      = ~bus.rect_h;
    bus.fill_colour = ~bus.fill_colour;
  endtask

  // Observe one fill against the expected clipped region; optional start poke.
  task automatic watch_fill(input string tag, input int ex0, input int ey0, input int ew,
                            input int eh, input int ecol, input int poke_cyc);
    int ex = ex0, ey = ey0;
    int nplot = 0, order_err = 0, col_err = 0, busy_err = 0, ndone = 0;
    int last_plot_cyc = -1, done_cyc = -1, last_x = -1, last_y = -1;
    int budget = ew * eh + 10;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (bus.plot === 1'b1) begin
        if (int'(bus.x) != ex || int'(bus.y) != ey) order_err++;
        if (int'(bus.colour) != ecol) col_err++;
        if (bus.busy !== 1'b1) busy_err++;
        last_x = int'(bus.x);
        last_y = int'(bus.y);
        nplot++;
        last_plot_cyc = cyc;
        ex++;
        if (ex == ex0 + ew) begin
          ex = ex0;
          ey++;
        end
      end
      if (bus.done === 1'b1) begin
        ndone++;
        done_cyc = cyc;
      end
      if (cyc == poke_cyc) begin
        bus.start = 1'b1; bus.mode = 1'b0;
        bus.rect_x0 = 8'd0; bus.rect_y0 = 7'd0; bus.rect_w = 8'd20; bus.rect_h = 7'd20;
      end else begin
        bus.start = 1'b0;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      @(negedge clock);
    end
    bus.start = 1'b0;
    check({tag, "_plots"}, 32'(nplot), 32'(ew * eh));
    check({tag, "_order"}, 32'(order_err), 32'd0);
    check({tag, "_colour"}, 32'(col_err), 32'd0);
    check({tag, "_busy"}, 32'(busy_err), 32'd0);
    check({tag, "_ndone"}, 32'(ndone), 32'd1);
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(last_plot_cyc + 1));
    if (ew * eh > 0) begin
      check({tag, "_last_x"}, 32'(last_x), 32'(ex0 + ew - 1));
      check({tag, "_last_y"}, 32'(last_y), 32'(ey0 + eh - 1));
    end else begin
      check({tag, "_noplot_x"}, 32'(last_x), 32'hFFFF_FFFF);
    end
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.mode = 1'b0;
    bus.rect_x0 = 8'd0; bus.rect_y0 = 7'd0; bus.rect_w = 8'd0; bus.rect_h = 7'd0;
    bus.fill_colour = 3'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_plot", 32'(bus.plot), 32'd0);
    check("rst_x", 32'(bus.x), 32'd0);
    check("rst_y", 32'(bus.y), 32'd0);
    check("rst_colour", 32'(bus.colour), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);

    // Start accepted in the very first IDLE cycle after reset.
    reset = 1'b0;
    do_start(1'b1, 10, 20, 3, 2, 5);
    watch_fill("rect", 10, 20, 3, 2, 5, -1);

    do_start(1'b1, 158, 118, 5, 5, 3);
    watch_fill("clip", 158, 118, 2, 2, 3, -1);

    do_start(1'b1, 5, 5, 0, 4, 1);
    watch_fill("w0", 0, 0, 0, 0, 1, -1);

    do_start(1'b1, 160, 5, 4, 4, 1);
    watch_fill("x160", 0, 0, 0, 0, 1, -1);

    do_start(1'b1, 5, 119, 4, 9, 6);
    watch_fill("hclip", 5, 119, 4, 1, 6, -1);

    do_start(1'b1, 30, 40, 3, 2, 2);
    watch_fill("busy_start", 30, 40, 3, 2, 2, 2);

    do_start(1'b1, 30, 40, 3, 2, 4);
    watch_fill("done_start", 30, 40, 3, 2, 4, 6);

    do_start(1'b0, 99, 99, 1, 1, 0);
    watch_fill("full", 0, 0, 160, 120, 0, -1);

    // Abort a full-screen fill at its 100th pixel.
    do_start(1'b0, 0, 0, 0, 0, 6);
    repeat (99) @(negedge clock);
    check("mid_x_before", 32'(bus.x), 32'd99);
    reset = 1'b1;
    @(negedge clock);
    check("mid_plot", 32'(bus.plot), 32'd0);
    check("mid_x", 32'(bus.x), 32'd0);
    check("mid_y", 32'(bus.y), 32'd0);
    check("mid_busy", 32'(bus.busy), 32'd0);
    check("mid_done", 32'(bus.done), 32'd0);
    check("mid_colour", 32'(bus.colour), 32'd0);
    reset = 1'b0;
    do_start(1'b1, 10, 20, 3, 2, 5);
    watch_fill("after_rst", 10, 20, 3, 2, 5, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
